// File: rtl/rv_core_mc.sv
// Multi-cycle RV32I-subset core: FETCH -> EXEC -> (MEM) -> FETCH, no overlap between instructions.
// Optional macro RV_CORE_MC_ILLEGAL_HALT_EN: illegal instructions park the core in HALT instead of acting as NOPs.
module rv_core_mc #(
  parameter int          NUMREG   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_val,
  input  logic        inst_valid,
  output logic [31:0] data_addr,
  input  logic [31:0] data_rd,
  output logic [31:0] data_wr,
  output logic        data_re,
  output logic        data_we,
  input  logic        data_ack,
  output logic        halted,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam int         IW   = (NUMREG > 16) ? 5 : 4;
  localparam logic [5:0] NREG = 6'(NUMREG);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] daddr_q, daddr_d;
  logic [31:0] dwr_q, dwr_d;
  logic        re_q, re_d;
  logic        we_q, we_d;
  logic [31:0] xreg_q [NUMREG];

  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_out, mem_sum;
  logic        alu_alt, legal, taken;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'b0};

  function automatic logic reg_ok(input logic [4:0] idx);
    return {1'b0, idx} < NREG;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'b0, $signed(a) < $signed(b)};
      3'b011:  r = {31'b0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Out-of-range indices read as zero; such instructions are rejected as illegal anyway.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && reg_ok(rs1)) rs1_val = xreg_q[rs1[IW-1:0]];
    if (rs2 != 5'd0 && reg_ok(rs2)) rs2_val = xreg_q[rs2[IW-1:0]];
  end

  assign alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
  assign alu_alt = (opcode == OPC_OP) ? f7[5] : (f3 == 3'b101 && f7[5]);
  assign alu_out = alu(f3, alu_alt, rs1_val, alu_b);
  assign mem_sum = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_OPIMM:  legal = reg_ok(rd) && reg_ok(rs1) &&
                          ((f3 == 3'b001) ? (f7 == 7'h00) :
                           (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1);
      OPC_OP:     legal = reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2) &&
                          ((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      OPC_LUI:    legal = reg_ok(rd);
      OPC_JAL:    legal = reg_ok(rd);
      OPC_BRANCH: legal = reg_ok(rs1) && reg_ok(rs2) && (f3 != 3'b010) && (f3 != 3'b011);
      OPC_LOAD:   legal = reg_ok(rd) && reg_ok(rs1) && (f3 == 3'b010);
      OPC_STORE:  legal = reg_ok(rs1) && reg_ok(rs2) && (f3 == 3'b010);
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  taken = (rs1_val == rs2_val);
      3'b001:  taken = (rs1_val != rs2_val);
      3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  taken = (rs1_val <  rs2_val);
      3'b111:  taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    daddr_d = daddr_q;
    dwr_d   = dwr_q;
    re_d    = re_q;
    we_d    = we_q;
    wr_en   = 1'b0;
    wr_idx  = rd;
    wr_data = '0;
    case (state_q)
      S_FETCH: begin
        if (inst_valid) begin
          ir_d    = inst_val;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 32'd4;
        if (!legal) begin
`ifdef RV_CORE_MC_ILLEGAL_HALT_EN
          state_d = S_HALT;
          pc_d    = pc_q;
`endif
        end else begin
          case (opcode)
            OPC_OPIMM, OPC_OP: begin
              wr_en   = 1'b1;
              wr_data = alu_out;
            end
            OPC_LUI: begin
              wr_en   = 1'b1;
              wr_data = imm_u;
            end
            OPC_JAL: begin
              wr_en   = 1'b1;
              wr_data = pc_q + 32'd4;
              pc_d    = (pc_q + imm_j) & ~32'd1;
            end
            OPC_BRANCH: begin
              if (taken) pc_d = pc_q + imm_b;
            end
            OPC_LOAD, OPC_STORE: begin
              pc_d    = pc_q;
              state_d = S_MEM;
              daddr_d = {mem_sum[31:2], 2'b00};
              re_d    = (opcode == OPC_LOAD);
              we_d    = (opcode == OPC_STORE);
              if (opcode == OPC_STORE) dwr_d = rs2_val;
            end
            default: ;
          endcase
        end
      end
      S_MEM: begin
        // Request stays asserted with stable address/data until the memory acknowledges.
        if ((re_q || we_q) && data_ack) begin
          wr_en   = re_q;
          wr_data = data_rd;
          re_d    = 1'b0;
          we_d    = 1'b0;
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      daddr_q <= '0;
      dwr_q   <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      for (int i = 0; i < NUMREG; i++) xreg_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      daddr_q <= daddr_d;
      dwr_q   <= dwr_d;
      re_q    <= re_d;
      we_q    <= we_d;
      if (wr_en && wr_idx != 5'd0 && reg_ok(wr_idx)) xreg_q[wr_idx[IW-1:0]] <= wr_data;
    end
  end

  assign inst_addr   = pc_q;
  assign data_addr   = daddr_q;
  assign data_wr     = dwr_q;
  assign data_re     = re_q;
  assign data_we     = we_q;
  assign dbg_state_o = state_q;
`ifdef RV_CORE_MC_ILLEGAL_HALT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_rv_core_mc.sv
// Directed bench for rv_core_mc: a 32-register core with a delayed-ack data memory and a 16-register
// core for the out-of-range register index case. Registers are observed through stores.
module tb_rv_core_mc;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [31:0] JAL_SELF = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_addr, inst_val, data_addr, data_rd, data_wr;
  logic        inst_valid, data_re, data_we, data_ack, halted;
  logic [1:0]  dbg_state;

  logic        rst16 = 1'b1;
  logic [31:0] inst_addr16, inst_val16, data_addr16, data_wr16;
  logic [31:0] data_rd16 = 32'h0;
  logic        data_ack16 = 1'b0;
  logic        data_re16, data_we16, halted16;
  logic [1:0]  dbg_state16;

  logic [31:0] imem [64];
  logic [31:0] imem16 [64];
  logic        imem_valid = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] st_q[$];
  logic [31:0] sa_q[$];
  logic [31:0] la_q[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  rv_core_mc dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_val(inst_val), .inst_valid(inst_valid),
    .data_addr(data_addr), .data_rd(data_rd), .data_wr(data_wr), .data_re(data_re),
    .data_we(data_we), .data_ack(data_ack), .halted(halted), .dbg_state_o(dbg_state)
  );

  rv_core_mc #(.NUMREG(16)) dut16 (
    .clk(clk), .rst(rst16), .inst_addr(inst_addr16), .inst_val(inst_val16), .inst_valid(1'b1),
    .data_addr(data_addr16), .data_rd(data_rd16), .data_wr(data_wr16), .data_re(data_re16),
    .data_we(data_we16), .data_ack(data_ack16), .halted(halted16), .dbg_state_o(dbg_state16)
  );

  // Clock / memories
  initial forever #5 clk = ~clk;
  assign inst_val   = imem[inst_addr[7:2]];
  assign inst_valid = imem_valid;
  assign inst_val16 = imem16[inst_addr16[7:2]];
  assign data_rd    = 32'hDEAD_BEEF;

  // Data memory responder: acks after ack_delay cycles of a held request.
  initial begin
    data_ack = 1'b0;
    forever begin
      @(negedge clk);
      if ((data_re || data_we) && !data_ack) begin
        if (wait_cnt >= ack_delay) begin
          data_ack = 1'b1;
          wait_cnt = 0;
        end else wait_cnt++;
      end else begin
        data_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && data_ack && data_we) begin
      st_q.push_back(data_wr);
      sa_q.push_back(data_addr);
    end
    if (!rst && data_ack && data_re) la_q.push_back(data_addr);
  end

  // Tiny assembler
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, OPI};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [4:0] rd);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = JAL_SELF;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    st_q.delete();
    sa_q.delete();
    la_q.delete();
  endtask

  task automatic test_reset();
    imem_valid = 1'b0;
    clear_prog();
    do_reset();
    checks += 7;
    if (inst_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", inst_addr, 32'h0); end
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    if (data_re !== 1'b0) begin errors++; $display("FAIL reset_re got %b exp 0", data_re); end
    if (data_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", data_we); end
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    if (data_addr !== 32'h0) begin errors++; $display("FAIL reset_daddr got %h exp 0", data_addr); end
    if (data_wr !== 32'h0) begin errors++; $display("FAIL reset_dwr got %h exp 0", data_wr); end
    step(3);
    checks += 2;
    if (inst_addr !== 32'h0) begin errors++; $display("FAIL fetch_stall_pc got %h exp 0", inst_addr); end
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL fetch_stall_state got %0d exp 0", dbg_state); end
    imem_valid = 1'b1;
  endtask

  task automatic test_addi();
    clear_prog();
    imem[0] = 32'hFFB0_0093;
    imem[1] = enc_s(12'd0, 5'd1, 5'd0);
    ack_delay = 0;
    do_reset();
    step(1);
    checks++;
    if (dbg_state !== 2'd1) begin errors++; $display("FAIL addi_exec_state got %0d exp 1", dbg_state); end
    step(1);
    checks += 2;
    if (inst_addr !== 32'h4) begin errors++; $display("FAIL addi_pc got %h exp 4", inst_addr); end
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL addi_back_fetch got %0d exp 0", dbg_state); end
    step(3);
    checks += 2;
    if (st_q.size() != 1 || st_q[0] !== 32'hFFFF_FFFB) begin
      errors++; $display("FAIL addi_x1 got %h (n=%0d) exp fffffffb", (st_q.size() > 0) ? st_q[0] : 32'hx, st_q.size());
    end
    if (inst_addr !== 32'h8) begin errors++; $display("FAIL sw_pc got %h exp 8", inst_addr); end
  endtask

  task automatic test_x0();
    clear_prog();
    imem[0] = enc_i(12'd9, 5'd0, 3'd0, 5'd2);
    imem[1] = enc_i(12'd7, 5'd0, 3'd0, 5'd0);
    imem[2] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd2);
    imem[3] = enc_s(12'd0, 5'd0, 5'd0);
    imem[4] = enc_s(12'd4, 5'd2, 5'd0);
    do_reset();
    step(14);
    checks += 3;
    if (st_q.size() != 2) begin errors++; $display("FAIL x0_store_count got %0d exp 2", st_q.size()); end
    else begin
      if (st_q[0] !== 32'h0) begin errors++; $display("FAIL x0_value got %h exp 0", st_q[0]); end
      if (st_q[1] !== 32'h0 || sa_q[1] !== 32'h4) begin
        errors++; $display("FAIL x2_add_zero got %h@%h exp 0@4", st_q[1], sa_q[1]);
      end
    end
  endtask

  task automatic test_alu();
    logic [31:0] got;
    logic [31:0] got_a;
    clear_prog();
    exp_q.delete();
    imem[0]  = enc_i(12'hFFB, 5'd0, 3'd0, 5'd1);                 // x1 = -5
    imem[1]  = enc_i(12'h003, 5'd0, 3'd0, 5'd2);                 // x2 = 3
    imem[2]  = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd3);  exp_q.push_back(32'h0000_0008);
    imem[3]  = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd4);  exp_q.push_back(32'h0000_0001);
    imem[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd5);  exp_q.push_back(32'h0000_0000);
    imem[5]  = enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd6);  exp_q.push_back(32'hFFFF_FFFF);
    imem[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd7);  exp_q.push_back(32'h1FFF_FFFF);
    imem[7]  = enc_i(12'h004, 5'd2, 3'b001, 5'd8);      exp_q.push_back(32'h0000_0030);
    imem[8]  = enc_i(12'h00F, 5'd1, 3'b100, 5'd9);      exp_q.push_back(32'hFFFF_FFF4);
    imem[9]  = enc_i(12'hFFF, 5'd2, 3'b011, 5'd10);     exp_q.push_back(32'h0000_0001);
    imem[10] = {20'h12345, 5'd11, 7'b0110111};          exp_q.push_back(32'h1234_5000);
    imem[11] = enc_i(12'h401, 5'd1, 3'b101, 5'd12);     exp_q.push_back(32'hFFFF_FFFD);
    imem[12] = enc_i(12'h7F0, 5'd1, 3'b111, 5'd13);     exp_q.push_back(32'h0000_07F0);
    imem[13] = enc_i(12'hFF0, 5'd2, 3'b110, 5'd14);     exp_q.push_back(32'hFFFF_FFF3);
    imem[14] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd15); exp_q.push_back(32'h0000_0003);
    imem[15] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd16); exp_q.push_back(32'hFFFF_FFFE);
    imem[16] = enc_r(7'h00, 5'd2, 5'd2, 3'b001, 5'd17); exp_q.push_back(32'h0000_0018);
    imem[17] = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd18); exp_q.push_back(32'hFFFF_FFF8);
    imem[18] = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd19); exp_q.push_back(32'hFFFF_FFFB);
    imem[19] = enc_i(12'hFFC, 5'd1, 3'b010, 5'd20);     exp_q.push_back(32'h0000_0001);
    imem[20] = enc_i(12'h01C, 5'd1, 3'b101, 5'd21);     exp_q.push_back(32'h0000_000F);
    imem[21] = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd22); exp_q.push_back(32'h0000_0000);
    for (int i = 0; i < 20; i++) imem[22+i] = enc_s(12'(4*i), 5'(3+i), 5'd0);
    do_reset();
    step(110);
    checks++;
    if (st_q.size() != 20) begin errors++; $display("FAIL alu_store_count got %0d exp 20", st_q.size()); end
    for (int i = 0; i < 20 && st_q.size() > 0; i++) begin
      got   = st_q.pop_front();
      got_a = sa_q.pop_front();
      checks++;
      if (got !== exp_q[i] || got_a !== 32'(4*i)) begin
        errors++; $display("FAIL alu_x%0d got %h@%h exp %h@%h", 3+i, got, got_a, exp_q[i], 32'(4*i));
      end
    end
  endtask

  task automatic test_mem_wait();
    clear_prog();
    imem[0] = enc_i(12'h100, 5'd0, 3'd0, 5'd1);
    imem[1] = enc_s(12'd8, 5'd1, 5'd1);
    ack_delay = 3;
    do_reset();
    step(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_we !== 1'b1 || data_re !== 1'b0 || data_addr !== 32'h108 ||
          data_wr !== 32'h100 || inst_addr !== 32'h4) begin
        errors++;
        $display("FAIL sw_hold_%0d got we=%b re=%b a=%h d=%h pc=%h exp we=1 re=0 a=108 d=100 pc=4",
                 i, data_we, data_re, data_addr, data_wr, inst_addr);
      end
      step(1);
    end
    checks++;
    if (data_we !== 1'b0 || inst_addr !== 32'h8) begin
      errors++; $display("FAIL sw_release got we=%b pc=%h exp we=0 pc=8", data_we, inst_addr);
    end
    ack_delay = 0;
  endtask

  task automatic test_load_branch();
    clear_prog();
    imem[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd1);
    imem[1] = enc_lw(12'd0, 5'd0, 5'd3);
    imem[2] = enc_s(12'h020, 5'd3, 5'd0);
    imem[3] = enc_b(13'h1FF8, 5'd0, 5'd3, 3'b001);
    do_reset();
    step(2);
    step(3);
    checks += 2;
    if (inst_addr !== 32'h8) begin errors++; $display("FAIL lw_pc got %h exp 8", inst_addr); end
    if (la_q.size() != 1 || la_q[0] !== 32'h0) begin errors++; $display("FAIL lw_addr count %0d exp 1 at 0", la_q.size()); end
    step(3);
    checks++;
    if (st_q.size() != 1 || st_q[0] !== 32'hDEAD_BEEF || sa_q[0] !== 32'h20) begin
      errors++; $display("FAIL lw_x3 got %h (n=%0d) exp deadbeef@20", (st_q.size() > 0) ? st_q[0] : 32'hx, st_q.size());
    end
    step(2);
    checks++;
    if (inst_addr !== 32'h4) begin errors++; $display("FAIL bne_back got %h exp 4", inst_addr); end
  endtask

  task automatic test_branch_jal();
    logic [31:0] exp_pc [8];
    exp_pc = '{32'd4, 32'd8, 32'd16, 32'd20, 32'd28, 32'd32, 32'd40, 32'd52};
    clear_prog();
    imem[0]  = enc_i(12'hFFB, 5'd0, 3'd0, 5'd1);
    imem[1]  = enc_i(12'h003, 5'd0, 3'd0, 5'd2);
    imem[2]  = enc_b(13'd8, 5'd2, 5'd1, 3'b100);    // BLT taken
    imem[3]  = enc_i(12'd1, 5'd0, 3'd0, 5'd5);
    imem[4]  = enc_b(13'd8, 5'd2, 5'd1, 3'b110);    // BLTU not taken
    imem[5]  = enc_b(13'd8, 5'd1, 5'd2, 3'b101);    // BGE taken
    imem[6]  = enc_i(12'd2, 5'd0, 3'd0, 5'd5);
    imem[7]  = enc_b(13'd8, 5'd2, 5'd1, 3'b000);    // BEQ not taken
    imem[8]  = enc_b(13'd8, 5'd2, 5'd1, 3'b111);    // BGEU taken
    imem[9]  = enc_i(12'd3, 5'd0, 3'd0, 5'd5);
    imem[10] = enc_j(21'd12, 5'd6);
    imem[11] = enc_i(12'd4, 5'd0, 3'd0, 5'd5);
    imem[12] = enc_i(12'd4, 5'd0, 3'd0, 5'd5);
    imem[13] = enc_s(12'd0, 5'd6, 5'd0);
    imem[14] = enc_s(12'd4, 5'd5, 5'd0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(2);
      checks++;
      if (inst_addr !== exp_pc[i]) begin errors++; $display("FAIL br_pc_%0d got %h exp %h", i, inst_addr, exp_pc[i]); end
    end
    step(6);
    checks += 2;
    if (st_q.size() != 2 || st_q[0] !== 32'd44 || st_q[1] !== 32'd0) begin
      errors++; $display("FAIL jal_link_skip got n=%0d first %h exp 2 stores 2c,0", st_q.size(), (st_q.size() > 0) ? st_q[0] : 32'hx);
    end
    if (inst_addr !== 32'd60) begin errors++; $display("FAIL jal_tail_pc got %h exp 3c", inst_addr); end
    step(2);
    checks++;
    if (inst_addr !== 32'd60) begin errors++; $display("FAIL jal_self got %h exp 3c", inst_addr); end
  endtask

  task automatic test_reset_in_mem();
    clear_prog();
    imem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1);
    imem[1] = enc_lw(12'd0, 5'd0, 5'd2);
    ack_delay = 100;
    do_reset();
    step(4);
    checks++;
    if (data_re !== 1'b1 || dbg_state !== 2'd2) begin
      errors++; $display("FAIL mem_pending got re=%b st=%0d exp re=1 st=2", data_re, dbg_state);
    end
    rst = 1'b1;
    imem[0] = enc_s(12'd0, 5'd1, 5'd0);
    imem[1] = JAL_SELF;
    step(1);
    checks += 2;
    if (data_re !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL rst_in_mem got re=%b st=%0d exp re=0 st=0", data_re, dbg_state);
    end
    if (inst_addr !== 32'h0) begin errors++; $display("FAIL rst_in_mem_pc got %h exp 0", inst_addr); end
    ack_delay = 0;
    rst = 1'b0;
    st_q.delete();
    sa_q.delete();
    step(3);
    checks++;
    if (st_q.size() != 1 || st_q[0] !== 32'h0) begin
      errors++; $display("FAIL rst_clears_x1 got %h (n=%0d) exp 0", (st_q.size() > 0) ? st_q[0] : 32'hx, st_q.size());
    end
  endtask

  task automatic test_rv32e_illegal();
    for (int i = 0; i < 64; i++) imem16[i] = JAL_SELF;
    imem16[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd17);
    rst16 = 1'b1;
    step(2);
    rst16 = 1'b0;
    step(2);
    checks += 2;
`ifdef RV_CORE_MC_ILLEGAL_HALT_EN
    if (halted16 !== 1'b1 || dbg_state16 !== 2'd3) begin errors++; $display("FAIL e_halt got h=%b st=%0d exp h=1 st=3", halted16, dbg_state16); end
    if (inst_addr16 !== 32'h0) begin errors++; $display("FAIL e_halt_pc got %h exp 0", inst_addr16); end
    step(4);
    checks++;
    if (inst_addr16 !== 32'h0 || halted16 !== 1'b1) begin errors++; $display("FAIL e_halt_hold got pc=%h h=%b exp 0,1", inst_addr16, halted16); end
`else
    if (halted16 !== 1'b0) begin errors++; $display("FAIL e_nop_halted got %b exp 0", halted16); end
    if (inst_addr16 !== 32'h4) begin errors++; $display("FAIL e_nop_pc got %h exp 4", inst_addr16); end
    step(4);
    checks++;
    if (inst_addr16 !== 32'h4 || halted16 !== 1'b0) begin errors++; $display("FAIL e_nop_hold got pc=%h h=%b exp 4,0", inst_addr16, halted16); end
`endif
    checks++;
    if (data_re16 !== 1'b0 || data_we16 !== 1'b0) begin errors++; $display("FAIL e_no_mem got re=%b we=%b exp 0,0", data_re16, data_we16); end
    rst16 = 1'b1;
    step(1);
    checks++;
    if (inst_addr16 !== 32'h0 || halted16 !== 1'b0 || dbg_state16 !== 2'd0) begin
      errors++; $display("FAIL e_reset got pc=%h h=%b st=%0d exp 0,0,0", inst_addr16, halted16, dbg_state16);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem16[i] = JAL_SELF;
    clear_prog();
    test_reset();
    test_addi();
    test_x0();
    test_alu();
    test_mem_wait();
    test_load_branch();
    test_branch_jal();
    test_reset_in_mem();
    test_rv32e_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
